mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It handshakes with the instruction and data memories and gates the register-file and PC write enables using the decoder's control outputs. It also detects illegal instructions and memory timeouts, and keeps cycle and retired-instruction counters.

---
 rtl/mc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mc_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer
// for the RV32I core, with illegal-instruction and memory-timeout traps.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   instr_valid         decoder valid, held stable DECODE..WB
//   MemRead, MemWrite   decoder load/store flags
//   RegWrite            decoder register-write flag
//   Branch, Jump        decoder branch / JAL-JALR flags
//   branch_taken        ALU branch compare result, valid in WB
//   imem_req/ready      instruction fetch handshake
//   ir_we               instruction register load strobe
//   dmem_req/we/ready   data memory handshake
//   rf_we, pc_we        register file / PC write strobes
//   pc_sel              0 = PC+4, 1 = branch/jump target
//   halt_req            park request, sampled in WB
//   state               FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 HALT=5 TRAP=6
//   illegal, bus_err    sticky trap causes
//   cycle_cnt           cycles spent outside HALT/TRAP
//   retired_cnt         instructions completed in WB
module mc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t        st;
    logic [WW-1:0] wait_cnt;
    logic          at_lim;

    // Last permitted wait cycle; a ready in this cycle still wins.
    assign at_lim = (TIMEOUT != 0) && (wait_cnt == WW'(LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_FETCH;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (st != S_HALT && st != S_TRAP)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            unique case (st)
                S_FETCH: begin
                    if (imem_ready) begin
                        st       <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (at_lim) begin
                        st       <= S_TRAP;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_DECODE: begin
                    if (!instr_valid) begin
                        st      <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    st <= (MemRead | MemWrite) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        st       <= S_WB;
                        wait_cnt <= '0;
                    end else if (at_lim) begin
                        st       <= S_TRAP;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_WB: begin
                    retired_cnt <= retired_cnt + CNT_W'(1);
                    st <= halt_req ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    if (!halt_req)
                        st <= S_FETCH;
                end
                S_TRAP: begin
                    st <= S_TRAP;
                end
                default: begin
                    st <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode straight from state so they track reset at once.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        unique case (1'b1)
            (st == S_FETCH): begin
                imem_req = 1'b1;
            end
            (st == S_MEM): begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
            end
            (st == S_WB): begin
                // Branches never write rd even if the decoder says so.
                rf_we  = RegWrite & ~Branch;
                pc_we  = 1'b1;
                pc_sel = Jump | (Branch & branch_taken);
            end
            default: begin
            end
        endcase
    end

    assign ir_we = imem_req & imem_ready;
    assign state = st;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed self-checking bench for mc_sequencer.
// Each task drives one scenario and checks its outputs inline.
module tb_mc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        Branch;
    logic        Jump;
    logic        branch_taken;
    logic        imem_req;
    logic        imem_ready;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        halt_req;
    logic [2:0]  state;
    logic        illegal;
    logic        bus_err;
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;

    int n_cmp;
    int n_err;

    mc_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .RegWrite(RegWrite),
        .Branch(Branch),
        .Jump(Jump),
        .branch_taken(branch_taken),
        .imem_req(imem_req),
        .imem_ready(imem_ready),
        .ir_we(ir_we),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ready(dmem_ready),
        .rf_we(rf_we),
        .pc_we(pc_we),
        .pc_sel(pc_sel),
        .halt_req(halt_req),
        .state(state),
        .illegal(illegal),
        .bus_err(bus_err),
        .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_in();
        instr_valid  = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        halt_req     = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, reset released.
    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (state !== 3'd0 || imem_req !== 1'b1 || illegal !== 1'b0 ||
            bus_err !== 1'b0 || cycle_cnt !== 32'd0 ||
            retired_cnt !== 32'd0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset: state=%0d imem_req=%b ill=%b berr=%b cyc=%0d ret=%0d, want 0 1 0 0 0 0",
                     state, imem_req, illegal, bus_err, cycle_cnt, retired_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        do_reset();
        instr_valid = 1'b1;
        RegWrite    = 1'b1;
        imem_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (state !== exp_st[i]) begin
                n_err++;
                $display("FAIL add_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (ir_we !== 1'b1) begin
                    n_err++;
                    $display("FAIL add_ir_we: got %b want 1", ir_we);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0) begin
                    n_err++;
                    $display("FAIL add_wb: rf_we=%b pc_we=%b pc_sel=%b want 1 1 0",
                             rf_we, pc_we, pc_sel);
                end
            end
            tick();
        end
        #1;
        n_cmp++;
        if (state !== 3'd0 || retired_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL add_end: state=%0d ret=%0d cyc=%0d want 0 1 4",
                     state, retired_cnt, cycle_cnt);
        end
    endtask

    task automatic test_load_wait();
        logic [2:0] exp_st [8];
        int         rf_hits;
        int         bad_mem;
        exp_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        rf_hits = 0;
        bad_mem = 0;
        do_reset();
        instr_valid = 1'b1;
        MemRead     = 1'b1;
        RegWrite    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_ready = (i == 0);
            dmem_ready = (i == 6);
            #1;
            n_cmp++;
            if (state !== exp_st[i]) begin
                n_err++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            if (state == 3'd3 && (dmem_req !== 1'b1 || dmem_we !== 1'b0))
                bad_mem++;
            if (rf_we === 1'b1)
                rf_hits++;
            tick();
        end
        #1;
        n_cmp++;
        if (bad_mem != 0 || rf_hits != 1) begin
            n_err++;
            $display("FAIL lw_strobes: bad_mem=%0d rf_hits=%0d want 0 1", bad_mem, rf_hits);
        end
        n_cmp++;
        if (state !== 3'd0 || cycle_cnt !== 32'd8 || retired_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL lw_end: state=%0d cyc=%0d ret=%0d want 0 8 1",
                     state, cycle_cnt, retired_cnt);
        end
    endtask

    task automatic test_branch(input logic taken);
        do_reset();
        instr_valid  = 1'b1;
        Branch       = 1'b1;
        RegWrite     = 1'b1;
        branch_taken = taken;
        imem_ready   = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd4 || rf_we !== 1'b0 || pc_we !== 1'b1 || pc_sel !== taken) begin
            n_err++;
            $display("FAIL beq_wb(taken=%b): state=%0d rf_we=%b pc_we=%b pc_sel=%b want 4 0 1 %b",
                     taken, state, rf_we, pc_we, pc_sel, taken);
        end
    endtask

    task automatic test_illegal();
        int bad;
        bad = 0;
        do_reset();
        instr_valid = 1'b0;
        MemWrite    = 1'b1;
        RegWrite    = 1'b1;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (dmem_req === 1'b1 || rf_we === 1'b1 || pc_we === 1'b1)
                bad++;
            tick();
        end
        #1;
        n_cmp++;
        if (state !== 3'd6 || illegal !== 1'b1 || bus_err !== 1'b0 ||
            cycle_cnt !== 32'd2 || retired_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL ill_trap: state=%0d ill=%b berr=%b cyc=%0d ret=%0d want 6 1 0 2 0",
                     state, illegal, bus_err, cycle_cnt, retired_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            if (dmem_req === 1'b1 || rf_we === 1'b1 || pc_we === 1'b1 ||
                imem_req === 1'b1)
                bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0 || state !== 3'd6 || cycle_cnt !== 32'd2 ||
            retired_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL ill_frozen: bad=%0d state=%0d cyc=%0d ret=%0d want 0 6 2 0",
                     bad, state, cycle_cnt, retired_cnt);
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (state !== 3'd0 || illegal !== 1'b0 || cycle_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL ill_reset: state=%0d ill=%b cyc=%0d want 0 0 0",
                     state, illegal, cycle_cnt);
        end
    endtask

    task automatic test_timeout();
        int wrong;
        wrong = 0;
        do_reset();
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (state !== 3'd0)
                wrong++;
            tick();
        end
        n_cmp++;
        if (wrong != 0 || state !== 3'd6 || bus_err !== 1'b1 ||
            illegal !== 1'b0 || cycle_cnt !== 32'd16) begin
            n_err++;
            $display("FAIL to_trap: wrong=%0d state=%0d berr=%b ill=%b cyc=%0d want 0 6 1 0 16",
                     wrong, state, bus_err, illegal, cycle_cnt);
        end
        do_reset();
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            imem_ready = (i == 15);
            tick();
        end
        n_cmp++;
        if (state !== 3'd1 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_ready_last: state=%0d berr=%b want 1 0", state, bus_err);
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        do_reset();
        instr_valid = 1'b1;
        MemWrite    = 1'b1;
        halt_req    = 1'b1;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            n_err++;
            $display("FAIL sw_mem: state=%0d req=%b we=%b want 3 1 1",
                     state, dmem_req, dmem_we);
        end
        tick();
        tick();
        n_cmp++;
        if (state !== 3'd5 || cycle_cnt !== 32'd5 || retired_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL halt_enter: state=%0d cyc=%0d ret=%0d want 5 5 1",
                     state, cycle_cnt, retired_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            if (state !== 3'd5 || imem_req !== 1'b0)
                bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0 || cycle_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL halt_hold: bad=%0d cyc=%0d want 0 5", bad, cycle_cnt);
        end
        halt_req = 1'b0;
        tick();
        n_cmp++;
        if (state !== 3'd0 || imem_req !== 1'b1 || cycle_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL halt_exit: state=%0d imem_req=%b cyc=%0d want 0 1 5",
                     state, imem_req, cycle_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_in();
        rst_n = 1'b1;
        #3;
        test_reset();
        test_add();
        test_load_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_timeout();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
